csr_unit: RTL
=============

// Module: csr_unit
// PURPOSE
// - Executes Zicsr instructions that the system-instruction decoder has classified and accepted.
// - Performs atomic read-modify-write on the machine-mode CSR file and returns the old value for rd.
// - Sits beside the register file in the execute stage.
// - The decoder supplies opcode fields, rs1 data and rd select; this unit answers with the rd write-back or illegal.
// PARAMETERS
// - HART_ID  0            value returned by mhartid (0xF14)
// - MTVEC_RST 32'h0000_0000  reset value of mtvec
// PORTS
// - clk         in   1   rising-edge clock
// - reset       in   1   synchronous, active-high reset
// - req_valid   in   1   CSR instruction presented (CSRRW/S/C/WI/SI/CI)
// - req_ready   out  1   unit idle, request accepted when valid&ready
// - req_fn3     in   3   instr[14:12]; 000/100 are not CSR ops -> illegal
// - req_csr     in   12  instr[31:20] CSR address
// - req_rs1_sel in   5   instr[19:15]; also zimm for *I forms
// - req_rd_sel  in   5   instr[11:7]
// - rs1_data    in   32  register-file value of rs1
// - instret_inc in   1   one instruction retired this cycle
// - rd_we       out  1   one-cycle pulse: write rd_data to rd_sel
// - rd_sel      out  5   destination register
// - rd_data     out  32  old CSR value
// - done        out  1   one-cycle pulse: request finished (legal or illegal)
// - illegal     out  1   valid with done; illegal-instruction exception
// BEHAVIOUR
// - Reset: req_ready=1; rd_we=0, done=0, illegal=0; rd_sel=0, rd_data=0; state=IDLE.
//   mtvec=MTVEC_RST; all other RW CSRs and counters = 0.
// - FSM IDLE -> READ -> WRITE -> IDLE.
//   - IDLE: on valid&ready, latch fn3, csr, rs1_sel, rd_sel, rs1_data; ready drops the next cycle.
//   - READ: old = csr_rd(addr); compute legality and new value.
//   - WRITE: commit the CSR if a write is required; pulse done, and rd_we if legal and rd_sel!=0.
//   - Back in IDLE ready=1, so a new request may be accepted the cycle after done.
//   - Latency: accept at edge N, done high in cycle N+2 (3 cycles per request).
// - Operand: src = fn3[2] ? {27'b0, rs1_sel} : rs1_data.
//   - RW: new = src.  RS: new = old | src.  RC: new = old & ~src.
// - Write intent:
//   - RW/RWI always write, including rd=0.
//   - RS/RC/RSI/RCI write only if rs1_sel!=0; CSR unchanged when rs1_sel=0.
// - Illegal, no CSR write and rd_we=0 in all cases:
//   - unimplemented address;
//   - write intent to a read-only address (csr[11:10]==2'b11);
//   - fn3 of 000 or 100.
// - CSR map:
//   - RW: mstatus 0x300 (only MIE[3], MPIE[7] writable; others read 0), mie 0x304, mtvec 0x305
//     (bits[1:0] forced 0), mscratch 0x340, mepc 0x341 (bit0 forced 0), mcause 0x342, mtval 0x343.
//   - RO: misa 0x301 = 32'h4000_0100 (RV32I); writes to it are ignored but legal.
//   - RO: mhartid 0xF14 = HART_ID; mip 0x344 reads 0.
// - Reset asserted mid-request: FSM returns to IDLE and no pending write commits.
// - A request presented while ready=0 is ignored; the issuer holds it.
// CONFIGURATION
// - CSR_COUNTERS_EN defined: 64-bit mcycle and minstret are implemented.
//   - mcycle increments every clock; minstret increments when instret_inc=1.
//   - mcycle/minstret are read-write: 0xB00/0xB80 select low/high halves of mcycle, 0xB02/0xB82 of minstret.
//   - cycle/instret are read-only aliases: 0xC00/0xC80 for cycle, 0xC02/0xC82 for instret.
//   - Counters wrap 2^64-1 -> 0.
//   - A CSR write in WRITE wins over the increment for the written half, and that half holds the written value.
//   - The carry into the other half is suppressed that cycle.
// - CSR_COUNTERS_EN undefined: no counters; every counter address is illegal; instret_inc is ignored.
// TESTING
// - Reset, then CSRRW mscratch, rs1_data=32'hDEAD_BEEF, rd=5 -> done at N+2, rd_we, rd_data=0; re-read gives DEAD_BEEF.
// - mscratch=32'hF0F0_0000; CSRRSI zimm=5'h0F, rd=0 -> rd_we=0; then CSRRC rs1_data=32'hF000_0000 -> rd_data=F0F0_000F, mscratch=00F0_000F.
// - CSRRS mhartid, rs1_sel=0 -> legal, rd_data=HART_ID.
// - CSRRW to mhartid, or any access to 0x7C0 -> illegal=1, rd_we=0, CSR unchanged.
// - CSRRWI mtvec zimm=5'h13 -> mtvec=32'h10; reset asserted in READ of a second request -> no write, ready=1 next cycle.
// - CSR_COUNTERS_EN: write mcycle (0xB00)=32'hFFFF_FFFF, high half=0 -> after 1 clock the high half reads 1 and the low half wraps to 0.
//   Without the macro, a 0xB00 access -> illegal.

Source files
------------

// File: rtl/csr_unit_if.sv
// Request / write-back bundle between the system-instruction decoder (master)
// and the Zicsr execution unit (slave).
interface csr_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_fn3;
  logic [11:0] req_csr;
  logic [4:0]  req_rs1_sel;
  logic [4:0]  req_rd_sel;
  logic [31:0] rs1_data;
  logic        rd_we;
  logic [4:0]  rd_sel;
  logic [31:0] rd_data;
  logic        done;
  logic        illegal;

  modport master (
    output req_valid, req_fn3, req_csr, req_rs1_sel, req_rd_sel, rs1_data,
    input  req_ready, rd_we, rd_sel, rd_data, done, illegal
  );

  modport slave (
    input  req_valid, req_fn3, req_csr, req_rs1_sel, req_rd_sel, rs1_data,
    output req_ready, rd_we, rd_sel, rd_data, done, illegal
  );
endinterface

// File: rtl/csr_unit.sv
// csr_unit: executes accepted Zicsr instructions (CSRRW/S/C and immediate forms)
// against the machine-mode CSR file, returning the old CSR value for rd.
// Each request takes three cycles: IDLE (accept) -> READ -> WRITE.
// Optional feature macro: CSR_COUNTERS_EN adds 64-bit mcycle/minstret and the
// read-only cycle/instret aliases; without it every counter address is illegal.
module csr_unit #(
  parameter logic [31:0] HART_ID   = 32'd0,
  parameter logic [31:0] MTVEC_RST = 32'h0000_0000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       instret_inc,
  csr_unit_if.slave  bus
);

  localparam logic [11:0] A_MSTATUS  = 12'h300;
  localparam logic [11:0] A_MISA     = 12'h301;
  localparam logic [11:0] A_MIE      = 12'h304;
  localparam logic [11:0] A_MTVEC    = 12'h305;
  localparam logic [11:0] A_MSCRATCH = 12'h340;
  localparam logic [11:0] A_MEPC     = 12'h341;
  localparam logic [11:0] A_MCAUSE   = 12'h342;
  localparam logic [11:0] A_MTVAL    = 12'h343;
  localparam logic [11:0] A_MIP      = 12'h344;
  localparam logic [11:0] A_MHARTID  = 12'hF14;
`ifdef CSR_COUNTERS_EN
  localparam logic [11:0] A_MCYCLE    = 12'hB00;
  localparam logic [11:0] A_MCYCLEH   = 12'hB80;
  localparam logic [11:0] A_MINSTRET  = 12'hB02;
  localparam logic [11:0] A_MINSTRETH = 12'hB82;
  localparam logic [11:0] A_CYCLE     = 12'hC00;
  localparam logic [11:0] A_CYCLEH    = 12'hC80;
  localparam logic [11:0] A_INSTRET   = 12'hC02;
  localparam logic [11:0] A_INSTRETH  = 12'hC82;
`endif

  localparam logic [31:0] MISA_VAL     = 32'h4000_0100;
  localparam logic [31:0] MSTATUS_MASK = 32'h0000_0088;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2
  } state_t;

  state_t      state_r;
  state_t      state_nx_s;

  // latched request
  logic [2:0]  fn3_r;
  logic [11:0] csr_r;
  logic [4:0]  rs1_sel_r;
  logic [4:0]  req_rd_r;
  logic [31:0] rs1_data_r;

  // READ-stage results carried into WRITE
  logic [31:0] old_r;
  logic [31:0] new_r;
  logic        commit_r;
  logic        illegal_r;

  // registered outputs
  logic        ready_r;
  logic        rd_we_r;
  logic [4:0]  rd_sel_r;
  logic [31:0] rd_data_r;
  logic        done_r;
  logic        illegal_out_r;

  // architectural CSRs
  logic [31:0] mstatus_r;
  logic [31:0] mie_r;
  logic [31:0] mtvec_r;
  logic [31:0] mscratch_r;
  logic [31:0] mepc_r;
  logic [31:0] mcause_r;
  logic [31:0] mtval_r;
`ifdef CSR_COUNTERS_EN
  logic [63:0] mcycle_r;
  logic [63:0] minstret_r;
`else
  logic        unused_s;
  assign unused_s = instret_inc;
`endif

  // combinational READ-stage signals
  logic        accept_s;
  logic        impl_s;
  logic [31:0] old_s;
  logic [31:0] src_s;
  logic [31:0] new_s;
  logic        wr_intent_s;
  logic        illegal_s;
  logic        wr_en_s;

  assign accept_s = bus.req_valid & ready_r;
  assign wr_en_s  = (state_r == ST_WRITE) & commit_r;

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // FSM next-state: one accepted request walks READ then WRITE
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_nx_s = ST_READ;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_READ:  state_nx_s = ST_WRITE;
      ST_WRITE: state_nx_s = ST_IDLE;
      default:  state_nx_s = ST_IDLE;
    endcase
  end

  // capture the request fields on acceptance
  always_ff @(posedge clk) begin
    if (reset) begin
      fn3_r      <= 3'd0;
      csr_r      <= 12'd0;
      rs1_sel_r  <= 5'd0;
      req_rd_r   <= 5'd0;
      rs1_data_r <= 32'd0;
    end else if (accept_s) begin
      fn3_r      <= bus.req_fn3;
      csr_r      <= bus.req_csr;
      rs1_sel_r  <= bus.req_rs1_sel;
      req_rd_r   <= bus.req_rd_sel;
      rs1_data_r <= bus.rs1_data;
    end
  end

  // CSR read mux: old value and whether the address exists
  always_comb begin
    impl_s = 1'b1;
    old_s  = 32'd0;
    case (csr_r)
      A_MSTATUS:  old_s = mstatus_r;
      A_MISA:     old_s = MISA_VAL;
      A_MIE:      old_s = mie_r;
      A_MTVEC:    old_s = mtvec_r;
      A_MSCRATCH: old_s = mscratch_r;
      A_MEPC:     old_s = mepc_r;
      A_MCAUSE:   old_s = mcause_r;
      A_MTVAL:    old_s = mtval_r;
      A_MIP:      old_s = 32'd0;
      A_MHARTID:  old_s = HART_ID;
`ifdef CSR_COUNTERS_EN
      A_MCYCLE,   A_CYCLE:    old_s = mcycle_r[31:0];
      A_MCYCLEH,  A_CYCLEH:   old_s = mcycle_r[63:32];
      A_MINSTRET, A_INSTRET:  old_s = minstret_r[31:0];
      A_MINSTRETH, A_INSTRETH: old_s = minstret_r[63:32];
`endif
      default: begin
        impl_s = 1'b0;
        old_s  = 32'd0;
      end
    endcase
  end

  // operand select, write intent, new value and legality
  always_comb begin
    src_s = fn3_r[2] ? {27'd0, rs1_sel_r} : rs1_data_r;
    wr_intent_s = 1'b0;
    new_s       = old_s;
    case (fn3_r[1:0])
      2'b01: begin
        wr_intent_s = 1'b1;
        new_s       = src_s;
      end
      2'b10: begin
        wr_intent_s = (rs1_sel_r != 5'd0);
        new_s       = old_s | src_s;
      end
      2'b11: begin
        wr_intent_s = (rs1_sel_r != 5'd0);
        new_s       = old_s & ~src_s;
      end
      default: begin
        wr_intent_s = 1'b0;
        new_s       = old_s;
      end
    endcase
    // read-only space is csr[11:10]==11; fn3[1:0]==00 is not a CSR op
    illegal_s = ~impl_s | (fn3_r[1:0] == 2'b00) |
                (wr_intent_s & (csr_r[11:10] == 2'b11));
  end

  // hold READ-stage results for the WRITE cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      old_r     <= 32'd0;
      new_r     <= 32'd0;
      commit_r  <= 1'b0;
      illegal_r <= 1'b0;
    end else if (state_r == ST_READ) begin
      old_r     <= old_s;
      new_r     <= new_s;
      commit_r  <= wr_intent_s & ~illegal_s;
      illegal_r <= illegal_s;
    end
  end

  // commit to the plain RW CSRs; RO-but-legal targets fall to default
  always_ff @(posedge clk) begin
    if (reset) begin
      mstatus_r  <= 32'd0;
      mie_r      <= 32'd0;
      mtvec_r    <= MTVEC_RST;
      mscratch_r <= 32'd0;
      mepc_r     <= 32'd0;
      mcause_r   <= 32'd0;
      mtval_r    <= 32'd0;
    end else if (wr_en_s) begin
      case (csr_r)
        A_MSTATUS:  mstatus_r  <= new_r & MSTATUS_MASK;
        A_MIE:      mie_r      <= new_r;
        A_MTVEC:    mtvec_r    <= {new_r[31:2], 2'b00};
        A_MSCRATCH: mscratch_r <= new_r;
        A_MEPC:     mepc_r     <= {new_r[31:1], 1'b0};
        A_MCAUSE:   mcause_r   <= new_r;
        A_MTVAL:    mtval_r    <= new_r;
        default: begin
        end
      endcase
    end
  end

`ifdef CSR_COUNTERS_EN
  // mcycle: free-running; a written half takes the value and blocks the carry
  always_ff @(posedge clk) begin
    if (reset) begin
      mcycle_r <= 64'd0;
    end else if (wr_en_s && (csr_r == A_MCYCLE)) begin
      mcycle_r[31:0] <= new_r;
    end else if (wr_en_s && (csr_r == A_MCYCLEH)) begin
      mcycle_r[63:32] <= new_r;
      mcycle_r[31:0]  <= mcycle_r[31:0] + 32'd1;
    end else begin
      mcycle_r <= mcycle_r + 64'd1;
    end
  end

  // minstret: counts retirements; same write-over-increment rule as mcycle
  always_ff @(posedge clk) begin
    if (reset) begin
      minstret_r <= 64'd0;
    end else if (wr_en_s && (csr_r == A_MINSTRET)) begin
      minstret_r[31:0] <= new_r;
    end else if (wr_en_s && (csr_r == A_MINSTRETH)) begin
      minstret_r[63:32] <= new_r;
      minstret_r[31:0]  <= minstret_r[31:0] + {31'd0, instret_inc};
    end else begin
      minstret_r <= minstret_r + {63'd0, instret_inc};
    end
  end
`endif

  // registered handshake and write-back outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      ready_r       <= 1'b1;
      rd_we_r       <= 1'b0;
      rd_sel_r      <= 5'd0;
      rd_data_r     <= 32'd0;
      done_r        <= 1'b0;
      illegal_out_r <= 1'b0;
    end else begin
      if (accept_s) begin
        ready_r <= 1'b0;
      end else if (state_r == ST_WRITE) begin
        ready_r <= 1'b1;
      end
      done_r        <= (state_r == ST_WRITE);
      illegal_out_r <= (state_r == ST_WRITE) & illegal_r;
      rd_we_r       <= (state_r == ST_WRITE) & ~illegal_r & (req_rd_r != 5'd0);
      if (state_r == ST_WRITE) begin
        rd_sel_r  <= req_rd_r;
        rd_data_r <= old_r;
      end
    end
  end

  assign bus.req_ready = ready_r;
  assign bus.rd_we     = rd_we_r;
  assign bus.rd_sel    = rd_sel_r;
  assign bus.rd_data   = rd_data_r;
  assign bus.done      = done_r;
  assign bus.illegal   = illegal_out_r;

endmodule
